// File: rtl/equiv_stream_checker_if.sv
// ---------------------------------------------------------------------------
// equiv_stream_checker_if
//   Bundles the two DUT output streams and the per-bit compare mask that feed
//   the equivalence checker.
//   Signals:
//     a_valid, y_a  : stream A sample and its valid
//     b_valid, y_b  : stream B sample and its valid
//     cmp_mask      : 1 = bit takes part in the compare
//   Modports:
//     master : harness side, drives the streams
//     slave  : checker side, observes the streams
// ---------------------------------------------------------------------------
interface equiv_stream_checker_if #(
  parameter int WIDTH = 91
);
  logic             a_valid;
  logic [WIDTH-1:0] y_a;
  logic             b_valid;
  logic [WIDTH-1:0] y_b;
  logic [WIDTH-1:0] cmp_mask;

  modport master (output a_valid, output y_a, output b_valid, output y_b, output cmp_mask);
  modport slave  (input  a_valid, input  y_a, input  b_valid, input  y_b, input  cmp_mask);
endinterface

// File: rtl/equiv_stream_checker.sv
// ---------------------------------------------------------------------------
// equiv_stream_checker
//   Equivalence monitor for differential fuzzing: compares stream A (delayed
//   by LAG cycles) with stream B under a per-bit mask, ignores a warm-up
//   window after reset/clear, keeps saturating statistics and captures the
//   first mismatching pair.
//   Ports:
//     clk, rst_n    : clock (rising edge), asynchronous active-low reset
//     clear         : synchronous restart of warm-up and statistics
//     bus           : stream A/B samples, valids and compare mask (slave)
//     fail          : sticky mismatch flag
//     state         : 00 WARMUP, 01 CHECK, 10 HALT
//     cycle_cnt     : cycles spent in CHECK
//     compare_cnt   : compare events evaluated in CHECK
//     mismatch_cnt  : mismatching events
//     first_a/b     : aligned A and B values of the first mismatch
//     first_cycle   : cycle_cnt value at the first mismatch
// ---------------------------------------------------------------------------
module equiv_stream_checker #(
  parameter int WIDTH        = 91,
  parameter int LAG          = 0,
  parameter int WARMUP_CYC   = 4,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  equiv_stream_checker_if.slave bus,
  output logic                 fail,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     compare_cnt,
  output logic [CNT_W-1:0]     mismatch_cnt,
  output logic [WIDTH-1:0]     first_a,
  output logic [WIDTH-1:0]     first_b,
  output logic [CNT_W-1:0]     first_cycle
);

  typedef enum logic [1:0] {
    WARMUP = 2'b00,
    CHECK  = 2'b01,
    HALT   = 2'b10
  } state_t;

  localparam logic [7:0] WARM_INIT = 8'(WARMUP_CYC);

  state_t           state_q, state_d;
  logic [7:0]       warm_q, warm_d;
  logic [WIDTH-1:0] a_dly;
  logic             vld_dly;
  logic             evt;
  logic             mis;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---- stage p0..pLAG-1: alignment line for stream A ----
  generate
    if (LAG == 0) begin : g_direct
      assign a_dly   = bus.y_a;
      assign vld_dly = bus.a_valid;
    end else begin : g_line
      logic [WIDTH-1:0] a_p [LAG];
      logic [LAG-1:0]   vld_p;

      // Valids are flushed by clear so stale A samples never form an event.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p <= '0;
        end else if (clear) begin
          vld_p <= '0;
        end else begin
          vld_p[0] <= bus.a_valid;
          for (int i = 1; i < LAG; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      always_ff @(posedge clk) begin
        a_p[0] <= bus.y_a;
        for (int i = 1; i < LAG; i++) a_p[i] <= a_p[i-1];
      end

      assign a_dly   = a_p[LAG-1];
      assign vld_dly = vld_p[LAG-1];
    end
  endgenerate

  // ---- compare (combinational, consumed at the next edge) ----
  // Case inequality makes an X/Z on any masked bit count as a mismatch.
  always_comb begin
    evt = vld_dly & bus.b_valid;
    mis = evt & ((((a_dly ^ bus.y_b) & bus.cmp_mask)) !== '0);
  end

  // Warm-up leaves on the edge where the counter would reach zero, so the
  // FSM spends exactly WARMUP_CYC cycles in WARMUP (WARMUP_CYC=0 -> one edge).
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    if (clear) begin
      state_d = WARMUP;
      warm_d  = WARM_INIT;
    end else begin
      case (state_q)
        WARMUP: begin
          warm_d = (warm_q == 8'd0) ? 8'd0 : warm_q - 8'd1;
          if (warm_q <= 8'd1) state_d = CHECK;
        end
        CHECK:   if (mis && (STOP_ON_FAIL != 0)) state_d = HALT;
        HALT:    state_d = HALT;
        default: state_d = WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WARMUP;
      warm_q  <= WARM_INIT;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
    end
  end

  // ---- stage p1: statistics and first-mismatch capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail         <= 1'b0;
      cycle_cnt    <= '0;
      compare_cnt  <= '0;
      mismatch_cnt <= '0;
      first_a      <= '0;
      first_b      <= '0;
      first_cycle  <= '0;
    end else if (clear) begin
      fail         <= 1'b0;
      cycle_cnt    <= '0;
      compare_cnt  <= '0;
      mismatch_cnt <= '0;
      first_a      <= '0;
      first_b      <= '0;
      first_cycle  <= '0;
    end else if (state_q == CHECK) begin
      cycle_cnt <= sat_inc(cycle_cnt);
      if (evt) compare_cnt <= sat_inc(compare_cnt);
      if (mis) begin
        mismatch_cnt <= sat_inc(mismatch_cnt);
        fail         <= 1'b1;
        if (mismatch_cnt == '0) begin
          first_a     <= a_dly;
          first_b     <= bus.y_b;
          first_cycle <= cycle_cnt;
        end
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_equiv_stream_checker.sv
// ---------------------------------------------------------------------------
// tb_equiv_stream_checker
//   Two checker instances: u0 (LAG=0, CNT_W=16, halting) and u1 (LAG=3,
//   CNT_W=4, free-running). Random streams are compared against a reference
//   model that keeps a sample history, plain integer statistics and
//   saturates only when reporting.
// ---------------------------------------------------------------------------
module tb_equiv_stream_checker;
  localparam int W = 91;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear0 = 1'b0;
  logic clear1 = 1'b0;

  equiv_stream_checker_if #(.WIDTH(W)) s0 ();
  equiv_stream_checker_if #(.WIDTH(W)) s1 ();

  logic          fail0, fail1;
  logic [1:0]    state0, state1;
  logic [15:0]   cyc0, cmp0, mm0, fc0;
  logic [3:0]    cyc1, cmp1, mm1, fc1;
  logic [W-1:0]  fa0, fb0, fa1, fb1;

  equiv_stream_checker #(.WIDTH(W), .LAG(0), .WARMUP_CYC(4), .CNT_W(16), .STOP_ON_FAIL(1)) u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear0), .bus(s0),
    .fail(fail0), .state(state0), .cycle_cnt(cyc0), .compare_cnt(cmp0), .mismatch_cnt(mm0),
    .first_a(fa0), .first_b(fb0), .first_cycle(fc0));

  equiv_stream_checker #(.WIDTH(W), .LAG(3), .WARMUP_CYC(4), .CNT_W(4), .STOP_ON_FAIL(0)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .bus(s1),
    .fail(fail1), .state(state1), .cycle_cnt(cyc1), .compare_cnt(cmp1), .mismatch_cnt(mm1),
    .first_a(fa1), .first_b(fb1), .first_cycle(fc1));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] ha [2][64];
  bit           hv [2][64];
  int           flush [2];
  int           mst [2];   // 0 warm-up, 1 checking, 2 halted
  int           wc [2], cyc [2], cmp [2], mm [2], mfc [2];
  bit           mfail [2];
  logic [W-1:0] mfa [2], mfb [2];
  int           tc = 0;

  function automatic int sat(input int v, input int cw);
    int mx;
    mx = (1 << cw) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic mreset(input int i);
    mst[i] = 0; wc[i] = 0; cyc[i] = 0; cmp[i] = 0; mm[i] = 0; mfc[i] = 0;
    mfail[i] = 1'b0; mfa[i] = '0; mfb[i] = '0;
  endtask

  task automatic model_cycle(input int i);
    logic [W-1:0] a, b, m, ad;
    bit av, bv, c, adv;
    int s, lag;
    lag = (i == 0) ? 0 : 3;
    if (i == 0) begin
      a = s0.y_a; av = s0.a_valid; b = s0.y_b; bv = s0.b_valid; m = s0.cmp_mask; c = clear0;
    end else begin
      a = s1.y_a; av = s1.a_valid; b = s1.y_b; bv = s1.b_valid; m = s1.cmp_mask; c = clear1;
    end
    ha[i][tc % 64] = a;
    hv[i][tc % 64] = av;
    if (lag == 0) begin
      ad = a; adv = av;
    end else begin
      s = tc - lag;
      adv = 1'b0; ad = '0;
      if (s >= 0) begin
        ad  = ha[i][s % 64];
        adv = (s > flush[i]) && hv[i][s % 64];
      end
    end
    if (c) begin
      mreset(i);
      flush[i] = tc;
    end else if (mst[i] == 0) begin
      wc[i]++;
      if (wc[i] >= 4) mst[i] = 1;
    end else if (mst[i] == 1) begin
      if (adv && bv) begin
        cmp[i]++;
        if (((ad ^ b) & m) != '0) begin
          if (mm[i] == 0) begin
            mfa[i] = ad; mfb[i] = b; mfc[i] = sat(cyc[i], (i == 0) ? 16 : 4);
          end
          mm[i]++;
          mfail[i] = 1'b1;
          if (i == 0) mst[i] = 2;
        end
      end
      cyc[i]++;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mreset(i);
        flush[i] = tc;
      end
      if (clk) tc++;
    end else begin
      for (int i = 0; i < 2; i++) model_cycle(i);
      tc++;
    end
  end

  task automatic check_model(input string ph);
    chk({ph, "_u0_fail"},  fail0,  mfail[0]);
    chk({ph, "_u0_state"}, state0, mst[0]);
    chk({ph, "_u0_cyc"},   cyc0,   sat(cyc[0], 16));
    chk({ph, "_u0_cmp"},   cmp0,   sat(cmp[0], 16));
    chk({ph, "_u0_mm"},    mm0,    sat(mm[0], 16));
    chk({ph, "_u0_fa"},    fa0,    mfa[0]);
    chk({ph, "_u0_fb"},    fb0,    mfb[0]);
    chk({ph, "_u0_fc"},    fc0,    mfc[0]);
    chk({ph, "_u1_fail"},  fail1,  mfail[1]);
    chk({ph, "_u1_state"}, state1, mst[1]);
    chk({ph, "_u1_cyc"},   cyc1,   sat(cyc[1], 4));
    chk({ph, "_u1_cmp"},   cmp1,   sat(cmp[1], 4));
    chk({ph, "_u1_mm"},    mm1,    sat(mm[1], 4));
    chk({ph, "_u1_fa"},    fa1,    mfa[1]);
    chk({ph, "_u1_fb"},    fb1,    mfb[1]);
    chk({ph, "_u1_fc"},    fc1,    mfc[1]);
  endtask

  // ---------------- stimulus ----------------
  int           vprob = 100;
  logic [W-1:0] mask0, mask1, fix_a, fix_b;
  logic [W-1:0] d1a [3];
  bit           d1v [3];

  function automatic logic [W-1:0] rnd();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // m0: 0 = B equals A, 1 = B has one flipped bit, 2 = fixed pair fix_a/fix_b.
  // f1: flip bit 0 of u1's B (B is A delayed by 3 cycles).
  task automatic step(input int m0, input bit f1, input bit c0, input bit c1);
    logic [W-1:0] a0, a1;
    bit v0, v1;
    a0 = rnd(); a1 = rnd();
    v0 = ($urandom_range(99) < vprob);
    v1 = ($urandom_range(99) < vprob);
    clear0 = c0; clear1 = c1;
    s0.cmp_mask = mask0;
    s0.a_valid = v0; s0.b_valid = v0; s0.y_a = a0;
    case (m0)
      1:       s0.y_b = a0 ^ ({{(W-1){1'b0}}, 1'b1} << $urandom_range(W-1));
      2:       begin s0.y_a = fix_a; s0.y_b = fix_b; s0.a_valid = 1'b1; s0.b_valid = 1'b1; end
      default: s0.y_b = a0;
    endcase
    s1.cmp_mask = mask1;
    s1.y_a = a1; s1.a_valid = v1;
    s1.y_b = d1a[2] ^ {{(W-1){1'b0}}, f1};
    s1.b_valid = d1v[2];
    d1a[2] = d1a[1]; d1v[2] = d1v[1];
    d1a[1] = d1a[0]; d1v[1] = d1v[0];
    d1a[0] = a1;     d1v[0] = v1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    mreset(0); mreset(1);
    flush[0] = 0; flush[1] = 0;
    mask0 = '1; mask1 = '1; fix_a = '0; fix_b = '0;
    for (int i = 0; i < 3; i++) begin d1a[i] = '0; d1v[i] = 1'b0; end
    s0.y_a = '0; s0.y_b = '0; s0.a_valid = 1'b0; s0.b_valid = 1'b0; s0.cmp_mask = '1;
    s1.y_a = '0; s1.y_b = '0; s1.a_valid = 1'b0; s1.b_valid = 1'b0; s1.cmp_mask = '1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", state0, 2'b00);
    chk("rst_fail", fail0, 1'b0);
    chk("rst_cmp", cmp0, 16'd0);
    chk("rst_fc", fc0, 16'd0);
    chk("rst_mm1", mm1, 4'd0);
    check_model("rst");
    rst_n = 1'b1;

    // Identical streams for 100 cycles, with a 5/7 mismatch inside warm-up
    for (int k = 0; k < 100; k++) begin
      if (k == 2) begin
        fix_a = 91'h5; fix_b = 91'h7;
        step(2, 1'b0, 1'b0, 1'b0);
      end else begin
        step(0, 1'b0, 1'b0, 1'b0);
      end
    end
    chk("t1_cmp", cmp0, 16'd96);
    chk("t1_fail", fail0, 1'b0);
    chk("t1_mm", mm0, 16'd0);
    chk("t1_state", state0, 2'b01);
    check_model("t1");

    // Random traffic with random masks and sporadic errors
    vprob = 70; mask0 = rnd(); mask1 = rnd();
    for (int k = 0; k < 80; k++)
      step(($urandom_range(9) == 0) ? 1 : 0, ($urandom_range(9) == 0), 1'b0, 1'b0);
    check_model("rand");

    // Halt on the first mismatch at CHECK cycle 10
    vprob = 100; mask0 = '1;
    step(0, 1'b0, 1'b1, 1'b0);
    repeat (14) step(0, 1'b0, 1'b0, 1'b0);
    fix_a = 91'h1234; fix_b = 91'h1235;
    step(2, 1'b0, 1'b0, 1'b0);
    repeat (5) step(1, 1'b0, 1'b0, 1'b0);
    chk("t3_fail", fail0, 1'b1);
    chk("t3_state", state0, 2'b10);
    chk("t3_mm", mm0, 16'd1);
    chk("t3_fa", fa0, 91'h1234);
    chk("t3_fb", fb0, 91'h1235);
    chk("t3_fc", fc0, 16'd10);
    check_model("t3");

    // LAG=3 stream with bit 0 flipped on 5 events, then the same with bit 0 masked
    for (int pass = 0; pass < 2; pass++) begin
      mask1 = '1;
      if (pass == 1) mask1[0] = 1'b0;
      step(0, 1'b0, 1'b0, 1'b1);
      repeat (10) step(0, 1'b0, 1'b0, 1'b0);
      repeat (5) step(0, 1'b1, 1'b0, 1'b0);
      repeat (3) step(0, 1'b0, 1'b0, 1'b0);
      chk(pass == 0 ? "t4_mm" : "t4m_mm", mm1, pass == 0 ? 4'd5 : 4'd0);
      chk(pass == 0 ? "t4_fail" : "t4m_fail", fail1, pass == 0 ? 1'b1 : 1'b0);
      chk(pass == 0 ? "t4_state" : "t4m_state", state1, 2'b01);
      check_model(pass == 0 ? "t4" : "t4m");
    end

    // Saturation with CNT_W=4
    mask1 = '1;
    step(0, 1'b0, 1'b0, 1'b1);
    repeat (7) step(0, 1'b0, 1'b0, 1'b0);
    repeat (20) step(0, 1'b1, 1'b0, 1'b0);
    chk("t5_mm", mm1, 4'd15);
    chk("t5_fail", fail1, 1'b1);
    chk("t5_cmp", cmp1, 4'd15);
    check_model("t5");

    // Clear in HALT together with a mismatch
    chk("t6_halt", state0, 2'b10);
    step(1, 1'b0, 1'b1, 1'b0);
    chk("t6_state", state0, 2'b00);
    chk("t6_fail", fail0, 1'b0);
    chk("t6_mm", mm0, 16'd0);
    chk("t6_cyc", cyc0, 16'd0);
    chk("t6_cmp", cmp0, 16'd0);
    chk("t6_fa", fa0, 91'h0);
    chk("t6_fc", fc0, 16'd0);
    repeat (4) step(0, 1'b0, 1'b0, 1'b0);
    chk("t6_warm_cyc", cyc0, 16'd0);
    chk("t6_warm_state", state0, 2'b01);
    step(0, 1'b0, 1'b0, 1'b0);
    chk("t6_first_cyc", cyc0, 16'd1);
    check_model("t6");

    // Reset pulse mid-CHECK while u1 holds a capture
    repeat (10) step(0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6r_fail1", fail1, 1'b0);
    chk("t6r_mm1", mm1, 4'd0);
    chk("t6r_fa1", fa1, 91'h0);
    chk("t6r_fb1", fb1, 91'h0);
    chk("t6r_cyc0", cyc0, 16'd0);
    chk("t6r_state0", state0, 2'b00);
    check_model("t6r");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    vprob = 70; mask0 = rnd(); mask1 = rnd();
    for (int k = 0; k < 40; k++)
      step(($urandom_range(7) == 0) ? 1 : 0, ($urandom_range(5) == 0), 1'b0, 1'b0);
    check_model("final");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
